// File: rtl/tdm_demux_rx_if.sv
// Bundle of the TDM receive-side signals: serial sample inputs and the recovered word/status outputs.
// The slave modport faces the receiver, and the master modport faces whoever drives the TDM line.
interface tdm_demux_rx_if #(
    parameter int ERR_W  = 8,
    parameter int FCNT_W = 16
);
    logic              en;
    logic              data_in;
    logic [3:0]        slot;
    logic [3:0]        word;
    logic              word_valid;
    logic              frame_err;
    logic              in_sync;
    logic [ERR_W-1:0]  err_cnt;
    logic [FCNT_W-1:0] frame_cnt;

    modport slave (
        input  en, data_in, slot,
        output word, word_valid, frame_err, in_sync, err_cnt, frame_cnt
    );

    modport master (
        output en, data_in, slot,
        input  word, word_valid, frame_err, in_sync, err_cnt, frame_cnt
    );
endinterface

// File: rtl/tdm_demux_rx.sv
// TDM slot demultiplexer: assembles 4 one-hot-strobed serial bits into a word and tracks sync, errors and frames.
// The word is updated at the edge that samples slot[3], so latency is one cycle. There is no backpressure; en low freezes all state.
module tdm_demux_rx #(
    parameter int ERR_W  = 8,
    parameter int FCNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    tdm_demux_rx_if.slave bus
);
    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic [0:0]        state, state_n;
    logic [1:0]        exp, exp_n;
    logic [3:0]        part, part_n;
    logic [3:0]        word, word_n;
    logic              word_vld, word_vld_n;
    logic              frame_err, frame_err_n;
    logic [ERR_W-1:0]  err_cnt, err_cnt_n;
    logic [FCNT_W-1:0] frame_cnt, frame_cnt_n;

    always_comb begin
        state_n     = state;
        exp_n       = exp;
        part_n      = part;
        word_n      = word;
        word_vld_n  = 1'b0;
        frame_err_n = 1'b0;
        err_cnt_n   = err_cnt;
        frame_cnt_n = frame_cnt;
        if (bus.en) begin
            if (state == HUNT) begin
                if (bus.slot == 4'b0001) begin
                    part_n  = {3'b000, bus.data_in};
                    exp_n   = 2'd1;
                    state_n = RECV;
                end
            end else if (bus.slot == (4'b0001 << exp)) begin
                if (exp == 2'd3) begin
                    word_n      = {bus.data_in, part[2:0]};
                    word_vld_n  = 1'b1;
                    frame_cnt_n = frame_cnt + {{(FCNT_W-1){1'b0}}, 1'b1};
                    exp_n       = 2'd0;
                    part_n      = 4'b0000;
                end else begin
                    part_n[exp] = bus.data_in;
                    exp_n       = exp + 2'd1;
                end
            end else begin
                // A stray slot 0 strobe is taken as the start of a new frame rather than a loss of sync.
                frame_err_n = 1'b1;
                if (err_cnt != {ERR_W{1'b1}})
                    err_cnt_n = err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
                if (bus.slot == 4'b0001) begin
                    part_n = {3'b000, bus.data_in};
                    exp_n  = 2'd1;
                end else begin
                    state_n = HUNT;
                    exp_n   = 2'd0;
                    part_n  = 4'b0000;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            exp       <= 2'd0;
            part      <= 4'b0000;
            word      <= 4'b0000;
            word_vld  <= 1'b0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            exp       <= exp_n;
            part      <= part_n;
            word      <= word_n;
            word_vld  <= word_vld_n;
            frame_err <= frame_err_n;
            err_cnt   <= err_cnt_n;
            frame_cnt <= frame_cnt_n;
        end
    end

    assign bus.word       = word;
    assign bus.word_valid = word_vld;
    assign bus.frame_err  = frame_err;
    assign bus.in_sync    = (state == RECV);
    assign bus.err_cnt    = err_cnt;
    assign bus.frame_cnt  = frame_cnt;
endmodule

// File: tb/tb_tdm_demux_rx.sv
// Directed bench for tdm_demux_rx: one default-width receiver plus a 2-bit error counter instance for saturation.
module tb_tdm_demux_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    tdm_demux_rx_if #(.ERR_W(8), .FCNT_W(16)) ifa ();
    tdm_demux_rx_if #(.ERR_W(2), .FCNT_W(16)) ifb ();

    tdm_demux_rx #(.ERR_W(8), .FCNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    tdm_demux_rx #(.ERR_W(2), .FCNT_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_chk++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, req);
        end
    endtask

    // Drive dut_a, take one rising edge, then settle before any checks.
    task automatic tick(input logic e, input logic [3:0] s, input logic d);
        ifa.en = e; ifa.slot = s; ifa.data_in = d;
        @(posedge clk);
        #1;
    endtask

    task automatic tickb(input logic e, input logic [3:0] s, input logic d);
        ifb.en = e; ifb.slot = s; ifb.data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.en = 1'b0; ifa.slot = 4'b0000; ifa.data_in = 1'b0;
        ifb.en = 1'b0; ifb.slot = 4'b0000; ifb.data_in = 1'b0;
        #12;
        chk("rst_word", ifa.word, 4'h0);
        chk("rst_wv", ifa.word_valid, 1'b0);
        chk("rst_fe", ifa.frame_err, 1'b0);
        chk("rst_sync", ifa.in_sync, 1'b0);
        chk("rst_err", ifa.err_cnt, 8'd0);
        chk("rst_fcnt", ifa.frame_cnt, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Normal frame: data 1,0,1,1
        tick(1'b1, 4'b0001, 1'b1);
        chk("s1_sync0", ifa.in_sync, 1'b1);
        chk("s1_wv0", ifa.word_valid, 1'b0);
        tick(1'b1, 4'b0010, 1'b0);
        tick(1'b1, 4'b0100, 1'b1);
        chk("s1_word_partial", ifa.word, 4'h0);
        tick(1'b1, 4'b1000, 1'b1);
        chk("s1_word", ifa.word, 4'b1101);
        chk("s1_wv", ifa.word_valid, 1'b1);
        chk("s1_fcnt", ifa.frame_cnt, 16'd1);
        chk("s1_sync", ifa.in_sync, 1'b1);
        chk("s1_fe", ifa.frame_err, 1'b0);

        // Back-to-back frames: 0,1,1,0 then 1,1,1,1
        tick(1'b1, 4'b0001, 1'b0);
        chk("s2_wv_pulse_end", ifa.word_valid, 1'b0);
        tick(1'b1, 4'b0010, 1'b1);
        tick(1'b1, 4'b0100, 1'b1);
        tick(1'b1, 4'b1000, 1'b0);
        chk("s2_word_a", ifa.word, 4'b0110);
        chk("s2_wv_a", ifa.word_valid, 1'b1);
        chk("s2_fcnt_a", ifa.frame_cnt, 16'd2);
        tick(1'b1, 4'b0001, 1'b1);
        chk("s2_gap1", ifa.word_valid, 1'b0);
        tick(1'b1, 4'b0010, 1'b1);
        chk("s2_gap2", ifa.word_valid, 1'b0);
        tick(1'b1, 4'b0100, 1'b1);
        chk("s2_gap3", ifa.word_valid, 1'b0);
        chk("s2_hold_word", ifa.word, 4'b0110);
        tick(1'b1, 4'b1000, 1'b1);
        chk("s2_word_b", ifa.word, 4'b1111);
        chk("s2_wv_b", ifa.word_valid, 1'b1);
        chk("s2_fcnt_b", ifa.frame_cnt, 16'd3);

        // Out-of-order slot: 0001, 0010, 1000
        tick(1'b1, 4'b0001, 1'b0);
        tick(1'b1, 4'b0010, 1'b0);
        tick(1'b1, 4'b1000, 1'b1);
        chk("s3_fe", ifa.frame_err, 1'b1);
        chk("s3_wv", ifa.word_valid, 1'b0);
        chk("s3_err", ifa.err_cnt, 8'd1);
        chk("s3_sync", ifa.in_sync, 1'b0);
        chk("s3_word", ifa.word, 4'b1111);
        tick(1'b1, 4'b0000, 1'b0);
        chk("s3_fe_end", ifa.frame_err, 1'b0);
        tick(1'b1, 4'b0011, 1'b1);
        chk("s3_hunt_multihot_fe", ifa.frame_err, 1'b0);
        chk("s3_hunt_multihot_sync", ifa.in_sync, 1'b0);
        chk("s3_hunt_err", ifa.err_cnt, 8'd1);

        // Restart on slot 0001: data 1,1,0,1,0,1
        tick(1'b1, 4'b0001, 1'b1);
        tick(1'b1, 4'b0010, 1'b1);
        tick(1'b1, 4'b0001, 1'b0);
        chk("s4_fe", ifa.frame_err, 1'b1);
        chk("s4_sync", ifa.in_sync, 1'b1);
        chk("s4_err", ifa.err_cnt, 8'd2);
        tick(1'b1, 4'b0010, 1'b1);
        chk("s4_fe_end", ifa.frame_err, 1'b0);
        tick(1'b1, 4'b0100, 1'b0);
        tick(1'b1, 4'b1000, 1'b1);
        chk("s4_word", ifa.word, 4'b1010);
        chk("s4_wv", ifa.word_valid, 1'b1);
        chk("s4_fe_done", ifa.frame_err, 1'b0);
        chk("s4_fcnt", ifa.frame_cnt, 16'd4);

        // Enable gap: slot strobes during en=0 must be ignored
        tick(1'b1, 4'b0001, 1'b1);
        tick(1'b1, 4'b0010, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 4'b1000, 1'b1);
            chk("s5_gap_wv", ifa.word_valid, 1'b0);
            chk("s5_gap_fe", ifa.frame_err, 1'b0);
        end
        chk("s5_gap_sync", ifa.in_sync, 1'b1);
        chk("s5_gap_fcnt", ifa.frame_cnt, 16'd4);
        tick(1'b1, 4'b0100, 1'b0);
        tick(1'b1, 4'b1000, 1'b0);
        chk("s5_word", ifa.word, 4'b0011);
        chk("s5_wv", ifa.word_valid, 1'b1);
        chk("s5_err", ifa.err_cnt, 8'd2);
        chk("s5_fcnt", ifa.frame_cnt, 16'd5);

        // Mid-frame asynchronous reset
        tick(1'b1, 4'b0001, 1'b1);
        tick(1'b1, 4'b0010, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5r_word", ifa.word, 4'h0);
        chk("s5r_sync", ifa.in_sync, 1'b0);
        chk("s5r_err", ifa.err_cnt, 8'd0);
        chk("s5r_fcnt", ifa.frame_cnt, 16'd0);
        tick(1'b1, 4'b0100, 1'b0);
        tick(1'b1, 4'b1000, 1'b0);
        chk("s5r_hold_wv", ifa.word_valid, 1'b0);
        chk("s5r_hold_sync", ifa.in_sync, 1'b0);
        rst_n = 1'b1;
        tick(1'b1, 4'b0001, 1'b0);
        chk("s5r_first_edge", ifa.in_sync, 1'b1);
        tick(1'b1, 4'b0010, 1'b1);
        tick(1'b1, 4'b0100, 1'b1);
        chk("s5r_no_wv", ifa.word_valid, 1'b0);
        tick(1'b1, 4'b1000, 1'b1);
        chk("s5r_word", ifa.word, 4'b1110);
        chk("s5r_wv", ifa.word_valid, 1'b1);
        chk("s5r_fcnt_new", ifa.frame_cnt, 16'd1);
        tick(1'b0, 4'b0000, 1'b0);

        // Error counter saturation on the 2-bit instance
        tickb(1'b1, 4'b0001, 1'b0);
        chk("s6_sync", ifb.in_sync, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            tickb(1'b1, 4'b0001, 1'b0);
            chk("s6_fe", ifb.frame_err, 1'b1);
            chk("s6_err", ifb.err_cnt, (i > 3) ? 32'd3 : 32'(i));
        end
        tickb(1'b1, 4'b0010, 1'b0);
        chk("s6_fe_end", ifb.frame_err, 1'b0);
        chk("s6_err_held", ifb.err_cnt, 2'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tdm_demux_rx.md
TDM_DEMUX_RX -- requirements
Module: tdm_demux_rx

Interface
REQ-001 The block SHALL have parameter ERR_W, default 8, setting the width of the error counter.
REQ-002 The block SHALL have parameter FCNT_W, default 16, setting the width of the frame counter.
REQ-003 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port en, input, 1 bit: sample enable; when low, no sampling and all state holds.
REQ-006 Port data_in, input, 1 bit: serial TDM data bit for the current slot.
REQ-007 Port slot, input, 4 bits: one-hot slot strobe, synchronous to clk; slot[k] high means data_in carries word bit k.
REQ-008 Port word, output, 4 bits: last completely received word, bit k taken from slot k.
REQ-009 Port word_valid, output, 1 bit: one-cycle pulse marking a new word.
REQ-010 Port frame_err, output, 1 bit: one-cycle pulse on a sequence or encoding violation while in sync.
REQ-011 Port in_sync, output, 1 bit: high while the state is RECV.
REQ-012 Port err_cnt, output, ERR_W bits: count of frame_err events.
REQ-013 Port frame_cnt, output, FCNT_W bits: count of completed words.

Function
REQ-014 data_in and slot SHALL be sampled together on each rising clk edge with en=1.
REQ-015 The FSM SHALL have two states, HUNT and RECV, plus a 2-bit expected-slot index exp.
REQ-016 In HUNT with slot=4'b0001: capture data_in into shift bit 0, set exp=1, go to RECV.
REQ-017 In HUNT with any other slot value, including 0000 or non-one-hot values: no capture, no error, stay in HUNT.
REQ-018 In RECV with slot equal to onehot(exp): capture data_in into partial bit exp, then increment exp modulo 4.
REQ-019 In RECV, a capture with exp=3 SHALL complete the frame.
- Load word with the 4 captured bits at that same edge.
- Assert word_valid for the following cycle only.
- Increment frame_cnt, wrapping modulo 2^FCNT_W.
- Stay in RECV with exp=0.
REQ-020 Latency SHALL be one cycle: word and word_valid update at the edge that samples slot[3], never later.
REQ-021 In RECV, any slot value other than onehot(exp) SHALL be a violation. This includes 0000, multi-hot values, and out-of-order values.
REQ-022 On a violation:
- Pulse frame_err for one cycle.
- Discard the partial word; word and word_valid are unaffected.
- Increment err_cnt, saturating at 2^ERR_W-1.
REQ-023 A violation where slot=4'b0001 SHALL restart the frame in the same edge: capture bit 0, set exp=1, remain in RECV.
REQ-024 Any other violation SHALL move the FSM to HUNT.
REQ-025 word SHALL hold its value between completed frames; partial captures SHALL never appear on word.
REQ-026 word_valid and frame_err SHALL never be asserted in the same cycle.
REQ-027 With en=0: no sampling, no pulses (word_valid and frame_err low), and FSM, exp, partial word and counters all held.
REQ-028 Resuming with en=1 SHALL continue the frame at the held exp.
REQ-029 in_sync SHALL be registered and reflect the state after each edge.

Reset
REQ-030 rst_n low SHALL, asynchronously and regardless of clk or en, force the following:
- state=HUNT, exp=0, partial word=0;
- word=0, word_valid=0, frame_err=0, in_sync=0;
- err_cnt=0, frame_cnt=0.
REQ-031 A reset asserted mid-frame SHALL discard the partial word; after release the block SHALL hunt for slot 4'b0001.
REQ-032 The first rising edge after rst_n deasserts SHALL be a normal sampling edge.

Verification
REQ-033 Scenario 1 (normal frame):
- Stimulus: en=1; slots 0001,0010,0100,1000 with data 1,0,1,1.
- Required response: word=4'b1101, one word_valid pulse, frame_cnt=1, in_sync=1.
REQ-034 Scenario 2 (back-to-back frames):
- Stimulus: two frames back-to-back, data 0,1,1,0 then 1,1,1,1.
- Required response: word=0110 then 1111, exactly 4 cycles between word_valid pulses, frame_cnt=2.
REQ-035 Scenario 3 (out-of-order slot):
- Stimulus: slots 0001,0010,1000.
- Required response: frame_err pulse, err_cnt=1, FSM in HUNT (in_sync=0), word unchanged, no word_valid.
REQ-036 Scenario 4 (restart on slot 0001):
- Stimulus: slots 0001,0010,0001,0010,0100,1000 with data 1,1,0,1,0,1.
- Required response: one frame_err at the third sample; in_sync stays 1; word=4'b1010; frame_cnt=1.
REQ-037 Scenario 5 (enable gap and mid-frame reset):
- Stimulus: slots 0001,0010, then en=0 for 3 cycles, then slots 0100,1000, with data 1,1,0,0.
- Required response: word=0011 and no error.
- Stimulus: repeat the frame, pulsing rst_n low after its second slot.
- Required response: all outputs 0 immediately; no word_valid until a fresh full frame.
REQ-038 Scenario 6 (error counter saturation):
- Stimulus: ERR_W=2, five violations.
- Required response: err_cnt=3 and held there; frame_err still pulses on each violation.
